dmem_responder: RTL and testbench

Handshaked data-memory responder that serves load/store requests issued by the core's MEM stage. It replaces the zero-latency combinational data memory with a registered, wait-stated memory, so that the pipeline's `ready_in` stall path is exercised. It holds a word-organised RAM with byte-lane write masks, checks alignment, and signals completion with a one-cycle `done` pulse.

---
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Wait-stated, handshaked data memory for the core's MEM stage: word RAM with
// byte-lane write masks, alignment checking and a one-cycle done pulse.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        read_write,
  input  logic [31:0] data_addr_in,
  input  logic [31:0] data_write_in,
  input  logic [3:0]  wb_mask,
  output logic        ready_out,
  output logic        done,
  output logic [31:0] inter_data,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t             state, state_nxt;
  logic [2:0]         cnt;
  logic               err_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         mask_q;
  logic               rw_q;
  logic [31:0]        mem [2**ADDR_W];
  logic               accept;
  logic               access;
  logic               bad;
  logic [ADDR_W-1:0]  idx;
  logic               unused_addr_bits;

  // Reads are never rejected; only full-word and half-word writes carry
  // an alignment requirement.
  function automatic logic misaligned(input logic rw, input logic [1:0] a,
                                      input logic [3:0] m);
    if (rw) return 1'b0;
    if (m == 4'b1111) return (a != 2'b00);
    if (m == 4'b0011 || m == 4'b1100) return a[0];
    return 1'b0;
  endfunction

  assign unused_addr_bits = ^data_addr_in[31:ADDR_W+2];

  assign ready_out    = (state == IDLE) || (state == RESP);
  assign accept       = enable && ready_out;
  assign access       = (state == BUSY) && (cnt == 3'd0);
  assign bad          = misaligned(rw_q, addr_q[1:0], mask_q);
  assign idx          = addr_q[ADDR_W+1:2];
  assign done         = (state == RESP);
  assign misalign_err = done && err_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == 3'd0) state_nxt = RESP;
      RESP:    state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      err_q      <= 1'b0;
      inter_data <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= WAIT_INIT;
      else if (state == BUSY && cnt != 3'd0)
        cnt <= cnt - 3'd1;
      if (access) begin
        err_q <= bad;
        if (bad)
          inter_data <= 32'd0;
        else if (rw_q)
          inter_data <= mem[idx];
      end
    end
  end

  // Request capture: data-only registers, qualified by the FSM.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= data_addr_in[ADDR_W+1:0];
      wdata_q <= data_write_in;
      mask_q  <= wb_mask;
      rw_q    <= read_write;
    end
  end

  always_ff @(posedge clk) begin
    if (access && !rw_q && !bad) begin
      for (int i = 0; i < 4; i++)
        if (mask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a word-array
// model of the memory, alignment rules and handshake latency.
module tb_dmem_responder;

  localparam int ADDR_W = 10;
  localparam int WAIT_CYCLES = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        read_write = 1'b1;
  logic [31:0] data_addr_in = '0;
  logic [31:0] data_write_in = '0;
  logic [3:0]  wb_mask = '0;
  logic        ready_out, done, misalign_err;
  logic [31:0] inter_data;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] model [2**ADDR_W];
  logic [31:0] last_data = 32'd0;

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset), .enable(enable), .read_write(read_write),
    .data_addr_in(data_addr_in), .data_write_in(data_write_in),
    .wb_mask(wb_mask), .ready_out(ready_out), .done(done),
    .inter_data(inter_data), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge where the responder should be ready, then
  // follow it to completion, checking every cycle against the model.
  task automatic access(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, input bit keep);
    int w;
    logic err;
    w = a[ADDR_W+1:2];
    enable = 1'b1; read_write = rw; data_addr_in = a; data_write_in = wd; wb_mask = m;
    chk("ready_at_request", {31'd0, ready_out}, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) enable = 1'b0;
    err = !rw && ((m == 4'hF && a[1:0] != 2'b00) ||
                  ((m == 4'h3 || m == 4'hC) && a[0]));
    if (err) last_data = 32'd0;
    else if (rw) last_data = model[w];
    else for (int i = 0; i < 4; i++)
      if (m[i]) model[w][8*i +: 8] = wd[8*i +: 8];
    for (int k = 1; k <= WAIT_CYCLES + 2; k++) begin
      @(negedge clk);
      if (k < WAIT_CYCLES + 2) begin
        chk("busy_ready", {31'd0, ready_out}, 32'd0);
        chk("busy_done", {31'd0, done}, 32'd0);
        chk("busy_err", {31'd0, misalign_err}, 32'd0);
      end else begin
        chk("resp_done", {31'd0, done}, 32'd1);
        chk("resp_ready", {31'd0, ready_out}, 32'd1);
        chk("resp_err", {31'd0, misalign_err}, {31'd0, err});
        chk("resp_data", inter_data, last_data);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    enable = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_ready", {31'd0, ready_out}, 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, ready_out}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, misalign_err}, 32'd0);
    chk({tag, "_data"}, inter_data, 32'd0);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  m;
    logic        rw;

    for (int i = 0; i < 2**ADDR_W; i++) model[i] = 32'd0;

    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2);

    // Basic write then read.
    access(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    idle_cycles(1);
    access(1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
    chk("basic_read", inter_data, 32'hDEADBEEF);
    idle_cycles(1);

    // Byte-lane write and misaligned suppression.
    access(1'b0, 32'h20, 32'h11223344, 4'hF, 1'b0);
    access(1'b0, 32'h20, 32'h0000AB00, 4'b0010, 1'b0);
    access(1'b1, 32'h20, 32'h0, 4'h0, 1'b0);
    chk("lane_read", inter_data, 32'h1122AB44);
    access(1'b0, 32'h22, 32'hFFFFFFFF, 4'hF, 1'b0);
    chk("misalign_flag", {31'd0, misalign_err}, 32'd1);
    chk("misalign_zero", inter_data, 32'd0);
    access(1'b1, 32'h20, 32'h0, 4'h0, 1'b0);
    chk("misalign_unchanged", inter_data, 32'h1122AB44);
    access(1'b0, 32'h21, 32'h0000FFFF, 4'b0011, 1'b0);
    access(1'b0, 32'h22, 32'h55660000, 4'b1100, 1'b0);
    access(1'b0, 32'h23, 32'hFFFFFFFF, 4'h0, 1'b0);
    access(1'b1, 32'h23, 32'h0, 4'hF, 1'b0);
    chk("half_read", inter_data, 32'h5566AB44);
    idle_cycles(1);

    // Back-to-back write then read of the same word, enable held high.
    access(1'b0, 32'h40, 32'hCAFEF00D, 4'hF, 1'b1);
    access(1'b1, 32'h40, 32'h0, 4'h0, 1'b1);
    chk("b2b_read", inter_data, 32'hCAFEF00D);
    idle_cycles(1);

    // Address wrap-around modulo RAM size.
    access(1'b0, 32'h1004, 32'h0BADC0DE, 4'hF, 1'b0);
    access(1'b1, 32'h0004, 32'h0, 4'h0, 1'b0);
    chk("wrap_read", inter_data, 32'h0BADC0DE);
    idle_cycles(1);

    // Reset during BUSY drops the pending write.
    enable = 1'b1; read_write = 1'b0; data_addr_in = 32'h40;
    data_write_in = 32'h12345678; wb_mask = 4'hF;
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", {31'd0, ready_out}, 32'd0);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    last_data = 32'd0;
    idle_cycles(1);
    access(1'b1, 32'h40, 32'h0, 4'h0, 1'b0);
    chk("dropped_write", inter_data, 32'hCAFEF00D);

    // Randomized traffic over a small, fully initialized window.
    for (int i = 0; i < 16; i++)
      access(1'b0, 32'h100 + 32'(4 * i), $urandom, 4'hF, 1'b0);
    for (int n = 0; n < 150; n++) begin
      rw = $urandom_range(0, 1);
      a  = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a + 32'h1000;
      wd = $urandom;
      m  = 4'($urandom_range(0, 15));
      access(rw, a, wd, m, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
